// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a combinational block under test, holds each one
// for SETTLE cycles, captures the block's outputs into a readable table and counts ones per output.
module truth_table_sequencer #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic [N_IN-1:0]           vec,
    input  logic [N_OUT-1:0]          res_in,
    output logic                      busy,
    output logic                      done,
    output logic                      row_valid,
    output logic [N_IN-1:0]           row_idx,
    output logic [N_OUT-1:0]          row_data,
    output logic [N_OUT*(N_IN+1)-1:0] ones_cnt,
    input  logic [N_IN-1:0]           rd_addr,
    output logic [N_OUT-1:0]          rd_data
);

    localparam int ROWS = 1 << N_IN;
    localparam int CW   = N_IN + 1;
    localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      row_q, row_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               row_valid_q, row_valid_d;
    logic [N_IN-1:0]    row_idx_q, row_idx_d;
    logic [N_OUT-1:0]   row_data_q, row_data_d;
    logic [CW-1:0]      ones_q [N_OUT];
    logic [CW-1:0]      ones_d [N_OUT];
    logic [N_OUT-1:0]   mem_q [ROWS];
    logic [N_OUT-1:0]   rd_data_q;
    logic               wr_en;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = done_q;
        row_valid_d = 1'b0;
        row_idx_d   = row_idx_q;
        row_data_d  = row_data_q;
        ones_d      = ones_q;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    row_d   = '0;
                    vec_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                    for (int k = 0; k < N_OUT; k++) ones_d[k] = '0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    vec_d   = '0;
                end else if (cnt_q == SW'(SETTLE - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            S_CAPTURE: begin
                // An aborted capture leaves table, counts and row_valid untouched.
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    vec_d   = '0;
                end else begin
                    wr_en       = 1'b1;
                    row_valid_d = 1'b1;
                    row_idx_d   = row_q[N_IN-1:0];
                    row_data_d  = res_in;
                    for (int k = 0; k < N_OUT; k++) ones_d[k] = ones_q[k] + CW'(res_in[k]);
                    if (row_q == CW'(ROWS - 1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        row_d   = row_q + CW'(1);
                        vec_d   = row_d[N_IN-1:0];
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            row_data_q  <= '0;
            for (int k = 0; k < N_OUT; k++) ones_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
            row_data_q  <= row_data_d;
            ones_q      <= ones_d;
        end
    end

    // Read samples the array before this edge's write lands, so a colliding read returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) mem_q[row_q[N_IN-1:0]] <= res_in;
            rd_data_q <= mem_q[rd_addr];
        end
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_ones
        assign ones_cnt[gi*CW +: CW] = ones_q[gi];
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign row_data  = row_data_q;
    assign rd_data   = rd_data_q;

endmodule
